bps_tick_ctrl: RTL and testbench
================================

BPS_TICK_CTRL -- requirements
Module: bps_tick_ctrl

Interface
REQ-001 SHALL have parameter DEF_DIV_LO, default 14'd10000, reset value of the low-stage divisor.
REQ-002 SHALL have parameter DEF_DIV_HI, default 14'd10000, reset value of the high-stage divisor.
REQ-003 SHALL have port clk, input, 1, the single clock of the block.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port cfg_we, input, 1, loads cfg_div_lo, cfg_div_hi, cfg_count and cfg_mode.
REQ-006 SHALL have ports cfg_div_lo and cfg_div_hi, input, 14 each, stage terminal values.
REQ-007 SHALL have port cfg_count, input, 8, tick count for one-shot mode.
REQ-008 SHALL have port cfg_mode, input, 1, where 0 = periodic and 1 = one-shot.
REQ-009 SHALL have ports start, stop and pause, input, 1 each, level-sampled control strobes.
REQ-010 SHALL have port tick, output, 1, single-cycle period pulse.
REQ-011 SHALL have port busy, output, 1, high in RUN or PAUSED.
REQ-012 SHALL have port done, output, 1, single-cycle pulse when a one-shot sequence completes.
REQ-013 SHALL have port tick_cnt, output, 8, ticks emitted since the last accepted start from IDLE.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and PAUSED.
REQ-015 SHALL use the two-stage prescaler as follows: lo counts 0..div_lo and then wraps; hi increments on each lo wrap; the terminal condition is lo==div_lo and hi==div_hi.
REQ-016 SHALL give a tick period P = (div_lo+1)*(div_hi+1) clock cycles.
REQ-017 SHALL make div_lo=div_hi=0 give P=1, with tick high on every RUN cycle.
REQ-018 SHALL, when start is sampled in IDLE at edge E0, go to RUN, clear lo, hi and tick_cnt, and assert the first tick in the cycle after edge E0+P, then every P cycles after that.
REQ-019 SHALL register tick and hold it high for exactly one cycle per terminal event.
REQ-020 SHALL, on a terminal event, clear both counters and increment tick_cnt; in periodic mode tick_cnt wraps from 255 to 0.
REQ-021 SHALL, in RUN, go to PAUSED when pause is sampled; counters and tick_cnt hold and no tick is emitted.
REQ-022 SHALL, in PAUSED, go back to RUN when start is sampled, resuming from the held count without clearing.
REQ-023 SHALL, in RUN or PAUSED, go to IDLE when stop is sampled, clearing the counters and keeping tick_cnt; no done pulse is given.
REQ-024 SHALL apply control priority stop > pause > start when strobes are sampled in the same cycle.
REQ-025 SHALL, in one-shot mode, on the terminal event that makes tick_cnt==cfg_count, emit tick and done in the same cycle and go to IDLE.
REQ-026 SHALL, for a one-shot start with cfg_count==0, emit done in the cycle after the start edge, stay IDLE and emit no tick.
REQ-027 SHALL accept cfg_we only in IDLE and ignore it in RUN or PAUSED.
REQ-028 SHALL, when cfg_we and start are sampled in IDLE in the same cycle, apply the new configuration to that run.
REQ-029 SHALL ignore start in RUN, and ignore pause in IDLE or PAUSED.
REQ-030 SHALL drive busy combinationally from the state.

Reset
REQ-031 SHALL, while rst_n is low, asynchronously force state=IDLE, lo=hi=0, tick=0, done=0, tick_cnt=0, div_lo=DEF_DIV_LO, div_hi=DEF_DIV_HI, count=0 and mode=periodic.
REQ-032 SHALL make reset mid-RUN or mid-PAUSED abort the sequence with no tick or done pulse, either during reset or on its release.
REQ-033 SHALL leave the block in IDLE after reset release until start is sampled.

Structure
REQ-034 SHALL keep shared package bps_pkg holding the divisor width (14), the count width (8), the default divisors and the FSM state encoding.
REQ-035 SHALL build the two-stage counter as one sub-module, bps_prescaler, with inputs clk, rst_n, en, clr, div_lo and div_hi, and output term.
REQ-036 SHALL keep the FSM, configuration registers, tick/done registers and tick_cnt in bps_tick_ctrl.

Verification
REQ-037 SHALL cover: cfg div_lo=2, div_hi=1, periodic, start -> tick 6 cycles after the start edge, then every 6 cycles; tick_cnt 1, 2, 3...
REQ-038 SHALL cover: one-shot, cfg_count=3, div_lo=div_hi=0 -> ticks on 3 consecutive cycles; done coincides with the 3rd tick; then busy=0.
REQ-039 SHALL cover: P=6, pause 2 cycles after start for 10 cycles, then start -> first tick delayed by exactly 10 cycles (16 after the original start).
REQ-040 SHALL cover: stop, pause and start asserted together in RUN -> IDLE, no tick, no done, tick_cnt retained.
REQ-041 SHALL cover: rst_n pulsed low mid-RUN with lo=1 -> all outputs 0, divisors back to 10000/10000, no tick after release.
REQ-042 SHALL cover: cfg_we with div_lo=0 during RUN -> ignored, period unchanged; one-shot with cfg_count=0 -> done 1 cycle after start, no tick.

Source files
------------

// File: rtl/bps_pkg.sv
// ----------------------------------------------------------------------------
// bps_pkg
// Shared definitions for the tick controller: divisor and tick-count widths,
// reset-default divisors, run-mode encoding and the controller FSM states.
// ----------------------------------------------------------------------------
package bps_pkg;

  localparam int DIV_W = 14;
  localparam int CNT_W = 8;

  localparam logic [DIV_W-1:0] BPS_DEF_DIV_LO = 14'd10000;
  localparam logic [DIV_W-1:0] BPS_DEF_DIV_HI = 14'd10000;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

endpackage

// File: rtl/bps_prescaler.sv
// ----------------------------------------------------------------------------
// bps_prescaler
// Two-stage period counter. The low stage counts 0..div_lo and wraps; the high
// stage advances on each low-stage wrap. term is asserted combinationally while
// both stages sit on their terminal values; the next enabled edge then clears
// both stages, so one full period is (div_lo+1)*(div_hi+1) enabled cycles.
//
// Ports
//   clk     clock
//   rst_n   asynchronous active-low reset, clears both stages
//   en      advance the counter this cycle
//   clr     clear both stages (dominates en)
//   div_lo  low-stage terminal value
//   div_hi  high-stage terminal value
//   term    both stages at their terminal values
// ----------------------------------------------------------------------------
module bps_prescaler
  import bps_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div_lo,
  input  logic [DIV_W-1:0] div_hi,
  output logic             term
);

  logic [DIV_W-1:0] lo;
  logic [DIV_W-1:0] hi;

  assign term = (lo == div_lo) && (hi == div_hi);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo <= '0;
      hi <= '0;
    end else if (clr) begin
      lo <= '0;
      hi <= '0;
    end else if (en) begin
      if (term) begin
        lo <= '0;
        hi <= '0;
      end else if (lo == div_lo) begin
        lo <= '0;
        hi <= hi + DIV_W'(1);
      end else begin
        lo <= lo + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/bps_tick_ctrl.sv
// ----------------------------------------------------------------------------
// bps_tick_ctrl
// Programmable period tick generator with periodic and one-shot modes,
// pause/resume and stop. Configuration is captured only while idle.
//
// Ports
//   clk         clock
//   rst_n       asynchronous active-low reset
//   cfg_we      load cfg_div_lo/cfg_div_hi/cfg_count/cfg_mode (idle only)
//   cfg_div_lo  low-stage terminal value
//   cfg_div_hi  high-stage terminal value
//   cfg_count   number of ticks in a one-shot sequence
//   cfg_mode    0 = periodic, 1 = one-shot
//   start       start from IDLE, resume from PAUSED
//   stop        abort to IDLE (tick_cnt kept, no done)
//   pause       freeze a running sequence
//   tick        one-cycle pulse per period
//   busy        running or paused
//   done        one-cycle pulse when a one-shot sequence completes
//   tick_cnt    ticks since the last start from IDLE
// ----------------------------------------------------------------------------
module bps_tick_ctrl
  import bps_pkg::*;
#(
  parameter logic [DIV_W-1:0] DEF_DIV_LO = BPS_DEF_DIV_LO,
  parameter logic [DIV_W-1:0] DEF_DIV_HI = BPS_DEF_DIV_HI
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [DIV_W-1:0] cfg_div_lo,
  input  logic [DIV_W-1:0] cfg_div_hi,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             cfg_mode,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tick_cnt
);

  state_t           state;
  logic [DIV_W-1:0] div_lo_q;
  logic [DIV_W-1:0] div_hi_q;
  logic [CNT_W-1:0] count_q;
  logic             mode_q;

  logic             term;
  logic             run_step;
  logic             pre_clr;
  logic [CNT_W-1:0] tick_cnt_nxt;
  logic             eff_mode;
  logic [CNT_W-1:0] eff_count;

  // A cycle advances the period when running without stop/pause, or on the
  // resume edge out of PAUSED: the resume edge counts, so a pause of N cycles
  // delays the next tick by exactly N cycles.
  assign run_step = !stop &&
                    (((state == ST_RUN) && !pause) ||
                     ((state == ST_PAUSED) && start));

  // Counters are held at zero throughout IDLE, which also covers the clear
  // on a start from IDLE.
  assign pre_clr = (state == ST_IDLE) || stop;

  assign busy         = (state != ST_IDLE);
  assign tick_cnt_nxt = tick_cnt + CNT_W'(1);

  // A start in the same cycle as a config write runs with the new settings.
  assign eff_mode  = cfg_we ? cfg_mode  : mode_q;
  assign eff_count = cfg_we ? cfg_count : count_q;

  bps_prescaler u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (run_step),
    .clr    (pre_clr),
    .div_lo (div_lo_q),
    .div_hi (div_hi_q),
    .term   (term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tick     <= 1'b0;
      done     <= 1'b0;
      tick_cnt <= '0;
      div_lo_q <= DEF_DIV_LO;
      div_hi_q <= DEF_DIV_HI;
      count_q  <= '0;
      mode_q   <= MODE_PERIODIC;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_we) begin
            div_lo_q <= cfg_div_lo;
            div_hi_q <= cfg_div_hi;
            count_q  <= cfg_count;
            mode_q   <= cfg_mode;
          end
          if (start && !stop) begin
            tick_cnt <= '0;
            // An empty one-shot completes immediately without running.
            if ((eff_mode == MODE_ONESHOT) && (eff_count == '0)) begin
              done <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end

        ST_RUN, ST_PAUSED: begin
          if (stop) begin
            state <= ST_IDLE;
          end else if ((state == ST_RUN) && pause) begin
            state <= ST_PAUSED;
          end else if (run_step) begin
            state <= ST_RUN;
            if (term) begin
              tick     <= 1'b1;
              tick_cnt <= tick_cnt_nxt;
              if ((mode_q == MODE_ONESHOT) && (tick_cnt_nxt == count_q)) begin
                done  <= 1'b1;
                state <= ST_IDLE;
              end
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bps_tick_ctrl.sv
module tb_bps_tick_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [13:0] cfg_div_lo;
  logic [13:0] cfg_div_hi;
  logic [7:0]  cfg_count;
  logic        cfg_mode;
  logic        start;
  logic        stop;
  logic        pause;
  logic        tick;
  logic        busy;
  logic        done;
  logic [7:0]  tick_cnt;

  bps_tick_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_div_lo (cfg_div_lo),
    .cfg_div_hi (cfg_div_hi),
    .cfg_count  (cfg_count),
    .cfg_mode   (cfg_mode),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .tick       (tick),
    .busy       (busy),
    .done       (done),
    .tick_cnt   (tick_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge index: value k after the k-th rising edge.
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          edge_no;
    logic        tick;
    logic        done;
    logic [7:0]  cnt;
  } ev_t;

  ev_t sb[$];

  typedef struct {
    logic [13:0] dl;
    logic [13:0] dh;
    logic        mode;
    logic [7:0]  cnt;
    logic        same;
    int          period;
    int          nticks;
  } vec_t;

  // Scoreboard: every tick/done pulse must match the next expected event.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n === 1'b1 && (tick === 1'b1 || done === 1'b1)) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse edge=%0d tick=%b done=%b tick_cnt=%0d required=no pulse",
                 edge_n, tick, done, tick_cnt);
      end else begin
        e = sb.pop_front();
        if (e.edge_no != edge_n || e.tick !== tick || e.done !== done || e.cnt !== tick_cnt) begin
          failures++;
          $display("FAIL pulse actual edge=%0d tick=%b done=%b cnt=%0d required edge=%0d tick=%b done=%b cnt=%0d",
                   edge_n, tick, done, tick_cnt, e.edge_no, e.tick, e.done, e.cnt);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input logic [13:0] dl, input logic [13:0] dh,
                     input logic m, input logic [7:0] c);
    cfg_div_lo = dl;
    cfg_div_hi = dh;
    cfg_mode   = m;
    cfg_count  = c;
    cfg_we     = 1'b1;
    cyc(1);
    cfg_we     = 1'b0;
  endtask

  task automatic do_start(output int e0);
    start = 1'b1;
    cyc(1);
    e0    = edge_n;
    start = 1'b0;
    cfg_we = 1'b0;
  endtask

  vec_t vecs[7];
  vec_t v;
  int   e0;

  initial begin
    rst_n = 1'b1; cfg_we = 1'b0; cfg_div_lo = '0; cfg_div_hi = '0;
    cfg_count = '0; cfg_mode = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;

    //           dl  dh  mode cnt same period nticks
    vecs[0] = '{14'd2, 14'd1, 1'b0, 8'd0, 1'b0,  6, 4};
    vecs[1] = '{14'd0, 14'd0, 1'b1, 8'd3, 1'b1,  1, 3};
    vecs[2] = '{14'd0, 14'd0, 1'b0, 8'd0, 1'b0,  1, 5};
    vecs[3] = '{14'd3, 14'd0, 1'b1, 8'd2, 1'b0,  4, 2};
    vecs[4] = '{14'd0, 14'd2, 1'b0, 8'd0, 1'b1,  3, 3};
    vecs[5] = '{14'd1, 14'd1, 1'b1, 8'd0, 1'b1,  4, 0};
    vecs[6] = '{14'd4, 14'd4, 1'b1, 8'd1, 1'b0, 25, 1};

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_tick", 32'(tick), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tick_cnt", 32'(tick_cnt), 0);
    chk("rst_div_lo", 32'(dut.div_lo_q), 10000);
    chk("rst_div_hi", 32'(dut.div_hi_q), 10000);
    chk("rst_mode", 32'(dut.mode_q), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(4);
    chk("idle_after_release", 32'(busy), 0);

    // Table-driven runs
    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      cfg_div_lo = v.dl; cfg_div_hi = v.dh; cfg_mode = v.mode; cfg_count = v.cnt;
      cfg_we = 1'b1;
      if (!v.same) begin
        cyc(1);
        cfg_we = 1'b0;
      end
      do_start(e0);
      if (v.mode && v.cnt == 8'd0) begin
        sb.push_back('{e0, 1'b0, 1'b1, 8'd0});
      end else begin
        for (int k = 1; k <= v.nticks; k++)
          sb.push_back('{e0 + k * v.period, 1'b1, 1'(v.mode && k == v.nticks), 8'(k)});
      end
      if (v.mode) begin
        cyc(v.nticks * v.period + 2);
        chk($sformatf("vec%0d_oneshot_idle", i), 32'(busy), 0);
        chk($sformatf("vec%0d_tick_cnt", i), 32'(tick_cnt), 32'(v.nticks));
      end else begin
        cyc(v.nticks * v.period);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk($sformatf("vec%0d_stopped", i), 32'(busy), 0);
        chk($sformatf("vec%0d_tick_cnt_kept", i), 32'(tick_cnt), 32'(v.nticks));
      end
      cyc(3);
      chk($sformatf("vec%0d_events_left", i), 32'(sb.size()), 0);
    end

    // Pause for 10 cycles delays the first tick by 10 cycles
    cfg(14'd2, 14'd1, 1'b0, 8'd0);
    do_start(e0);
    sb.push_back('{e0 + 16, 1'b1, 1'b0, 8'd1});
    sb.push_back('{e0 + 22, 1'b1, 1'b0, 8'd2});
    cyc(1);
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    chk("paused_busy", 32'(busy), 1);
    cyc(9);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(10);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    cyc(2);
    chk("pause_events_left", 32'(sb.size()), 0);
    chk("pause_tick_cnt", 32'(tick_cnt), 2);

    // stop + pause + start together in RUN
    cfg(14'd2, 14'd1, 1'b0, 8'd0);
    do_start(e0);
    sb.push_back('{e0 + 6, 1'b1, 1'b0, 8'd1});
    cyc(7);
    stop = 1'b1; pause = 1'b1; start = 1'b1;
    cyc(1);
    stop = 1'b0; pause = 1'b0; start = 1'b0;
    chk("all_strobes_idle", 32'(busy), 0);
    chk("all_strobes_tick_cnt", 32'(tick_cnt), 1);
    cyc(10);
    chk("all_strobes_events_left", 32'(sb.size()), 0);

    // cfg_we during RUN is ignored
    cfg(14'd2, 14'd1, 1'b0, 8'd0);
    do_start(e0);
    sb.push_back('{e0 + 6, 1'b1, 1'b0, 8'd1});
    sb.push_back('{e0 + 12, 1'b1, 1'b0, 8'd2});
    cyc(2);
    cfg_div_lo = 14'd0; cfg_div_hi = 14'd0; cfg_mode = 1'b1; cfg_count = 8'd1;
    cfg_we = 1'b1;
    cyc(1);
    cfg_we = 1'b0;
    cyc(9);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("run_cfg_ignored_div_lo", 32'(dut.div_lo_q), 2);
    cyc(3);
    chk("run_cfg_events_left", 32'(sb.size()), 0);

    // Reset mid-RUN with lo=1 after one tick
    cfg(14'd2, 14'd1, 1'b0, 8'd0);
    do_start(e0);
    sb.push_back('{e0 + 6, 1'b1, 1'b0, 8'd1});
    cyc(7);
    chk("pre_reset_lo", 32'(dut.u_prescaler.lo), 1);
    chk("pre_reset_tick_cnt", 32'(tick_cnt), 1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_tick", 32'(tick), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_tick_cnt", 32'(tick_cnt), 0);
    chk("mid_rst_div_lo", 32'(dut.div_lo_q), 10000);
    chk("mid_rst_div_hi", 32'(dut.div_hi_q), 10000);
    cyc(2);
    rst_n = 1'b1;
    cyc(20);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_events_left", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
